decode_reg_read: RTL and testbench

//  Decode stage of the Y86-64 pipeline, the read side of the register file that write-back updates.

---
 rtl/decode_reg_read.sv | 188 ++++++++++++++++++
 tb/tb_decode_reg_read.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_reg_read.sv
// Y86-64 decode stage: register-id decode, register read with E/M/W forwarding, E pipeline register.
// Define FORWARDING_DISABLE_EN to remove forwarding (valA/valB then come only from the register file or valP).
module decode_reg_read #(
    parameter int         WIDTH  = 64,
    parameter logic [3:0] RNONE  = 4'hF,
    parameter logic [3:0] RSP_ID = 4'h4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       D_stat,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       D_ifun,
    input  logic [3:0]       D_rA,
    input  logic [3:0]       D_rB,
    input  logic [WIDTH-1:0] D_valC,
    input  logic [WIDTH-1:0] D_valP,
    input  logic [3:0]       e_dstE,
    input  logic [WIDTH-1:0] e_valE,
    input  logic [3:0]       M_dstE,
    input  logic [WIDTH-1:0] M_valE,
    input  logic [3:0]       M_dstM,
    input  logic [WIDTH-1:0] m_valM,
    input  logic [3:0]       W_dstE,
    input  logic [WIDTH-1:0] W_valE,
    input  logic [3:0]       W_dstM,
    input  logic [WIDTH-1:0] W_valM,
    input  logic [WIDTH-1:0] reg_in0,
    input  logic [WIDTH-1:0] reg_in1,
    input  logic [WIDTH-1:0] reg_in2,
    input  logic [WIDTH-1:0] reg_in3,
    input  logic [WIDTH-1:0] reg_in4,
    input  logic [WIDTH-1:0] reg_in5,
    input  logic [WIDTH-1:0] reg_in6,
    input  logic [WIDTH-1:0] reg_in7,
    input  logic [WIDTH-1:0] reg_in8,
    input  logic [WIDTH-1:0] reg_in9,
    input  logic [WIDTH-1:0] reg_in10,
    input  logic [WIDTH-1:0] reg_in11,
    input  logic [WIDTH-1:0] reg_in12,
    input  logic [WIDTH-1:0] reg_in13,
    input  logic [WIDTH-1:0] reg_in14,
    input  logic             E_stall,
    input  logic             E_bubble,
    output logic [3:0]       d_srcA,
    output logic [3:0]       d_srcB,
    output logic [2:0]       E_stat,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_ifun,
    output logic [WIDTH-1:0] E_valC,
    output logic [WIDTH-1:0] E_valA,
    output logic [WIDTH-1:0] E_valB,
    output logic [3:0]       E_dstE,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB
);

    logic [WIDTH-1:0] rf [0:15];
    logic [3:0]       srcA_d, srcB_d, dstE_d, dstM_d;
    logic [WIDTH-1:0] valA_d, valB_d, valC_d;

    logic [2:0]       stat_q;
    logic [3:0]       icode_q, ifun_q, dstE_q, dstM_q, srcA_q, srcB_q;
    logic [WIDTH-1:0] valC_q, valA_q, valB_q;

    assign rf[0]  = reg_in0;
    assign rf[1]  = reg_in1;
    assign rf[2]  = reg_in2;
    assign rf[3]  = reg_in3;
    assign rf[4]  = reg_in4;
    assign rf[5]  = reg_in5;
    assign rf[6]  = reg_in6;
    assign rf[7]  = reg_in7;
    assign rf[8]  = reg_in8;
    assign rf[9]  = reg_in9;
    assign rf[10] = reg_in10;
    assign rf[11] = reg_in11;
    assign rf[12] = reg_in12;
    assign rf[13] = reg_in13;
    assign rf[14] = reg_in14;
    assign rf[15] = '0;

    // Decode: register ids per instruction class
    always_comb begin
        srcA_d = RNONE;
        srcB_d = RNONE;
        dstE_d = RNONE;
        dstM_d = RNONE;
        case (D_icode)
            4'h2: begin srcA_d = D_rA;   dstE_d = D_rB; end
            4'h3: begin dstE_d = D_rB; end
            4'h4: begin srcA_d = D_rA;   srcB_d = D_rB; end
            4'h5: begin srcB_d = D_rB;   dstM_d = D_rA; end
            4'h6: begin srcA_d = D_rA;   srcB_d = D_rB;   dstE_d = D_rB; end
            4'h8: begin srcB_d = RSP_ID; dstE_d = RSP_ID; end
            4'h9: begin srcA_d = RSP_ID; srcB_d = RSP_ID; dstE_d = RSP_ID; end
            4'hA: begin srcA_d = D_rA;   srcB_d = RSP_ID; dstE_d = RSP_ID; end
            4'hB: begin srcA_d = RSP_ID; srcB_d = RSP_ID; dstE_d = RSP_ID; dstM_d = D_rA; end
            default: ;
        endcase
    end

    assign d_srcA = srcA_d;
    assign d_srcB = srcB_d;

    // Read and forward: youngest in-flight producer wins, RNONE never matches
    always_comb begin
        valA_d = (srcA_d == RNONE) ? '0 : rf[srcA_d];
        valB_d = (srcB_d == RNONE) ? '0 : rf[srcB_d];
`ifndef FORWARDING_DISABLE_EN
        if (srcA_d != RNONE) begin
            if      (srcA_d == e_dstE) valA_d = e_valE;
            else if (srcA_d == M_dstM) valA_d = m_valM;
            else if (srcA_d == M_dstE) valA_d = M_valE;
            else if (srcA_d == W_dstM) valA_d = W_valM;
            else if (srcA_d == W_dstE) valA_d = W_valE;
        end
        if (srcB_d != RNONE) begin
            if      (srcB_d == e_dstE) valB_d = e_valE;
            else if (srcB_d == M_dstM) valB_d = m_valM;
            else if (srcB_d == M_dstE) valB_d = M_valE;
            else if (srcB_d == W_dstM) valB_d = W_valM;
            else if (srcB_d == W_dstE) valB_d = W_valE;
        end
`endif
        if (D_icode == 4'h7 || D_icode == 4'h8)
            valA_d = D_valP;
        valC_d = (D_icode <= 4'hB) ? D_valC : '0;
    end

`ifdef FORWARDING_DISABLE_EN
    logic unused_fwd;
    assign unused_fwd = ^{e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
                          W_dstE, W_valE, W_dstM, W_valM};
`endif

    // E pipeline register: reset/bubble load a nop, stall holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q  <= 3'd1;
            icode_q <= 4'h1;
            ifun_q  <= 4'h0;
            valC_q  <= '0;
            valA_q  <= '0;
            valB_q  <= '0;
            dstE_q  <= RNONE;
            dstM_q  <= RNONE;
            srcA_q  <= RNONE;
            srcB_q  <= RNONE;
        end else if (!E_stall) begin
            if (E_bubble) begin
                stat_q  <= 3'd1;
                icode_q <= 4'h1;
                ifun_q  <= 4'h0;
                valC_q  <= '0;
                valA_q  <= '0;
                valB_q  <= '0;
                dstE_q  <= RNONE;
                dstM_q  <= RNONE;
                srcA_q  <= RNONE;
                srcB_q  <= RNONE;
            end else begin
                stat_q  <= D_stat;
                icode_q <= D_icode;
                ifun_q  <= D_ifun;
                valC_q  <= valC_d;
                valA_q  <= valA_d;
                valB_q  <= valB_d;
                dstE_q  <= dstE_d;
                dstM_q  <= dstM_d;
                srcA_q  <= srcA_d;
                srcB_q  <= srcB_d;
            end
        end
    end

    assign E_stat  = stat_q;
    assign E_icode = icode_q;
    assign E_ifun  = ifun_q;
    assign E_valC  = valC_q;
    assign E_valA  = valA_q;
    assign E_valB  = valB_q;
    assign E_dstE  = dstE_q;
    assign E_dstM  = dstM_q;
    assign E_srcA  = srcA_q;
    assign E_srcB  = srcB_q;

endmodule

// File: tb/tb_decode_reg_read.sv
// Scoreboard bench for decode_reg_read: random and directed decode stimulus against a behavioural model.
// Honours FORWARDING_DISABLE_EN the same way the design does.
module tb_decode_reg_read;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } e_t;

    localparam e_t NOP = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0, valC: 64'd0, valA: 64'd0,
                           valB: 64'd0, dstE: 4'hF, dstM: 4'hF, srcA: 4'hF, srcB: 4'hF};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  D_stat = 3'd1;
    logic [3:0]  D_icode = 4'h1, D_ifun = 4'h0, D_rA = 4'hF, D_rB = 4'hF;
    logic [63:0] D_valC = '0, D_valP = '0;
    logic [3:0]  e_dstE = 4'hF, M_dstE = 4'hF, M_dstM = 4'hF, W_dstE = 4'hF, W_dstM = 4'hF;
    logic [63:0] e_valE = '0, M_valE = '0, m_valM = '0, W_valE = '0, W_valM = '0;
    logic [63:0] rf [0:14];
    logic        E_stall = 1'b0, E_bubble = 1'b0;
    logic [3:0]  d_srcA, d_srcB;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;

    int n_tests = 0;
    int n_fail  = 0;
    e_t sb_q[$];
    e_t st;

    always #5 clk = ~clk;

    decode_reg_read #(.WIDTH(64), .RNONE(4'hF), .RSP_ID(4'h4)) dut (
        .clk(clk), .rst(rst), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM),
        .reg_in0(rf[0]), .reg_in1(rf[1]), .reg_in2(rf[2]), .reg_in3(rf[3]),
        .reg_in4(rf[4]), .reg_in5(rf[5]), .reg_in6(rf[6]), .reg_in7(rf[7]),
        .reg_in8(rf[8]), .reg_in9(rf[9]), .reg_in10(rf[10]), .reg_in11(rf[11]),
        .reg_in12(rf[12]), .reg_in13(rf[13]), .reg_in14(rf[14]),
        .E_stall(E_stall), .E_bubble(E_bubble), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value a register id reads in decode: youngest pending writer first, then the file.
    function automatic logic [63:0] operand(input logic [3:0] id);
        logic [3:0]  pend_id  [5];
        logic [63:0] pend_val [5];
        if (id == 4'hF) return 64'd0;
`ifndef FORWARDING_DISABLE_EN
        pend_id  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        pend_val = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        for (int k = 0; k < 5; k++)
            if (pend_id[k] == id) return pend_val[k];
`endif
        return rf[id];
    endfunction

    function automatic e_t model_load();
        e_t r;
        logic [3:0] ic;
        ic = D_icode;
        r.stat  = D_stat;
        r.icode = ic;
        r.ifun  = D_ifun;
        r.srcA  = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? D_rA :
                  (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
        r.srcB  = (ic inside {4'h4, 4'h5, 4'h6}) ? D_rB :
                  (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        r.dstE  = (ic inside {4'h2, 4'h3, 4'h6}) ? D_rB :
                  (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        r.dstM  = (ic inside {4'h5, 4'hB}) ? D_rA : 4'hF;
        r.valC  = (ic > 4'hB) ? 64'd0 : D_valC;
        r.valA  = (ic == 4'h7 || ic == 4'h8) ? D_valP : operand(r.srcA);
        r.valB  = operand(r.srcB);
        return r;
    endfunction

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic issue();
        e_t exp;
        #1;
        exp = model_load();
        chk("d_srcA", {60'd0, d_srcA}, {60'd0, exp.srcA});
        chk("d_srcB", {60'd0, d_srcB}, {60'd0, exp.srcB});
        if (E_stall)       exp = st;
        else if (E_bubble) exp = NOP;
        st = exp;
        sb_q.push_back(exp);
        @(negedge clk);
    endtask

    task automatic clear_fwd();
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        E_stall = 1'b0; E_bubble = 1'b0;
    endtask

    function automatic logic [3:0] rnd_id();
        return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 5));
    endfunction

    always @(posedge clk) begin
        e_t exp;
        #1;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            n_tests++;
            if ({E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB} !== exp) begin
                n_fail++;
                $display("FAIL ereg: got %h expected %h",
                         {E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB}, exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 15; i++) rf[i] = 64'h1000 + 64'(i);
        st = NOP;
        @(negedge clk);
        @(negedge clk);
        chk("rst_icode", {60'd0, E_icode}, 64'd1);
        chk("rst_dstE", {60'd0, E_dstE}, 64'hF);
        rst = 1'b0;

        // irmov chain
        clear_fwd();
        rf[3] = 64'd5; D_stat = 3'd1; D_icode = 4'h6; D_ifun = 4'h0; D_rA = 4'h3; D_rB = 4'h3;
        e_dstE = 4'h3; e_valE = 64'd9;
        issue();
`ifdef FORWARDING_DISABLE_EN
        chk("chain_valA", E_valA, 64'd5);
`else
        chk("chain_valA", E_valA, 64'd9);
        chk("chain_valB", E_valB, 64'd9);
`endif
        chk("chain_dstE", {60'd0, E_dstE}, 64'd3);

        // forwarding priority
        clear_fwd();
        D_icode = 4'h2; D_rA = 4'h2; D_rB = 4'h1;
        M_dstM = 4'h2; m_valM = 64'd7; W_dstE = 4'h2; W_valE = 64'd8;
        issue();
`ifndef FORWARDING_DISABLE_EN
        chk("prio_M", E_valA, 64'd7);
`endif
        e_dstE = 4'h2; e_valE = 64'd6;
        issue();
`ifndef FORWARDING_DISABLE_EN
        chk("prio_e", E_valA, 64'd6);
`endif

        // call
        clear_fwd();
        D_icode = 4'h8; D_valP = 64'h40; rf[4] = 64'h100; D_rA = 4'hF; D_rB = 4'hF;
        issue();
        chk("call_valA", E_valA, 64'h40);
        chk("call_valB", E_valB, 64'h100);
        chk("call_dstE", {60'd0, E_dstE}, 64'd4);
        chk("call_srcA", {60'd0, E_srcA}, 64'hF);

        // control: stall holds, bubble loads nop, both hold
        D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2; E_stall = 1'b1;
        issue();
        chk("stall_icode", {60'd0, E_icode}, 64'h8);
        E_stall = 1'b0; E_bubble = 1'b1;
        issue();
        chk("bubble_icode", {60'd0, E_icode}, 64'h1);
        E_stall = 1'b1; D_icode = 4'h3;
        issue();
        chk("both_icode", {60'd0, E_icode}, 64'h1);

        // popq
        clear_fwd();
        D_icode = 4'hB; D_rA = 4'h5; D_rB = 4'hF;
        #1;
        chk("popq_srcA", {60'd0, d_srcA}, 64'h4);
        chk("popq_srcB", {60'd0, d_srcB}, 64'h4);
        @(negedge clk);
        issue();
        chk("popq_dstM", {60'd0, E_dstM}, 64'h5);

        // async reset mid-operation
        #2 rst = 1'b1;
        #1;
        chk("arst_icode", {60'd0, E_icode}, 64'd1);
        chk("arst_stat", {61'd0, E_stat}, 64'd1);
        chk("arst_srcA", {60'd0, E_srcA}, 64'hF);
        chk("arst_valA", E_valA, 64'd0);
        st = NOP;
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0)
                for (int i = 0; i < 15; i++) rf[i] = {$urandom, $urandom};
            D_stat  = 3'($urandom_range(1, 4));
            D_icode = 4'($urandom_range(0, 15));
            D_ifun  = 4'($urandom);
            D_rA    = rnd_id();
            D_rB    = rnd_id();
            D_valC  = {$urandom, $urandom};
            D_valP  = {$urandom, $urandom};
            e_dstE  = rnd_id(); e_valE = {$urandom, $urandom};
            M_dstE  = rnd_id(); M_valE = {$urandom, $urandom};
            M_dstM  = rnd_id(); m_valM = {$urandom, $urandom};
            W_dstE  = rnd_id(); W_valE = {$urandom, $urandom};
            W_dstM  = rnd_id(); W_valM = {$urandom, $urandom};
            E_stall  = ($urandom_range(0, 7) == 0);
            E_bubble = ($urandom_range(0, 7) == 0);
            issue();
        end

        @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
